// File: rtl/icache_refill.sv
// Block-refill engine: fetches one aligned BLK_BYTES block byte-by-byte from RAM and writes it to the icache.
// Optional feature: define ICACHE_REFILL_ABORT_EN to let clear_in abort an in-flight refill.
module icache_refill #(
  parameter int ADDR_W    = 32,
  parameter int BLK_BYTES = 64
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear_in,
  input  logic                   miss_en,
  input  logic [ADDR_W-1:0]      miss_addr,
  output logic                   busy,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  input  logic [7:0]             mem_din,
  output logic                   fill_en,
  output logic [ADDR_W-1:0]      fill_addr,
  output logic [8*BLK_BYTES-1:0] fill_data
);

  localparam int OFF_W = $clog2(BLK_BYTES);
  localparam int CNT_W = OFF_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         issue_cnt_q, recv_cnt_q;
  logic                     pend_q;
  logic [ADDR_W-1:0]        base_q, mem_a_q, fill_addr_q;
  logic [8*BLK_BYTES-1:0]   blk_buf, fill_data_q;
  logic                     accept, issue, capture, abort;

`ifdef ICACHE_REFILL_ABORT_EN
  assign abort  = (state_q == FETCH) && clear_in;
  assign accept = (state_q == IDLE) && miss_en && rdy_in && !clear_in;
`else
  logic unused_clear;
  assign unused_clear = clear_in;
  assign abort  = 1'b0;
  assign accept = (state_q == IDLE) && miss_en && rdy_in;
`endif

  // RAM answers even while paused, so capture depends only on the pending flag.
  assign capture = (state_q == FETCH) && pend_q;
  assign issue   = (state_q == FETCH) && rdy_in && (issue_cnt_q < CNT_W'(BLK_BYTES));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    mem_a   = mem_a_q;
    if (issue) mem_a = base_q + ADDR_W'(issue_cnt_q);
    unique case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH: begin
        if (abort)
          state_d = IDLE;
        else if (capture && recv_cnt_q == CNT_W'(BLK_BYTES - 1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pend_q      <= 1'b0;
      base_q      <= '0;
      mem_a_q     <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= issue && !abort;
      if (accept) begin
        base_q      <= miss_addr & ~ADDR_W'(BLK_BYTES - 1);
        issue_cnt_q <= '0;
        recv_cnt_q  <= '0;
      end
      if (issue) begin
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
        mem_a_q     <= mem_a;
      end
      if (capture) recv_cnt_q <= recv_cnt_q + CNT_W'(1);
      if (state_q == DONE) begin
        fill_addr_q <= base_q;
        fill_data_q <= blk_buf;
      end
    end
  end

  // NOTE: the assembly buffer is not reset; every byte is rewritten before it can reach fill_data.
  always_ff @(posedge clk) begin
    if (capture) blk_buf[{recv_cnt_q[OFF_W-1:0], 3'b000} +: 8] <= mem_din;
  end

  assign busy      = (state_q != IDLE);
  assign mem_wr    = 1'b0;
  assign fill_en   = (state_q == DONE);
  assign fill_addr = fill_en ? base_q  : fill_addr_q;
  assign fill_data = fill_en ? blk_buf : fill_data_q;

endmodule
